// File: rtl/wb_pkg.sv
// Shared widths, queue entry type and writeback source select for writeback_arbiter.
package wb_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned NREGS  = 1 << ADDR_W;

    typedef struct packed {
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } wb_req_t;

    typedef enum logic [1:0] {
        WB_NONE,
        WB_ALU,
        WB_QUEUE,
        WB_BYPASS
    } wb_src_e;

endpackage

// File: rtl/writeback_arbiter_if.sv
// Writeback bus: ALU and memory result inputs, issue tracking, register-file write port.
interface writeback_arbiter_if;
    import wb_pkg::*;

    logic              alu_valid;
    logic [ADDR_W-1:0] alu_rd;
    logic [DATA_W-1:0] alu_data;
    logic              alu_stall;
    logic              mem_valid;
    logic              mem_ready;
    logic [ADDR_W-1:0] mem_rd;
    logic [DATA_W-1:0] mem_data;
    logic              issue_valid;
    logic [ADDR_W-1:0] issue_rd;
    logic [NREGS-1:0]  busy;
    logic              wb_wren;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;

    modport master (
        output alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data, issue_valid, issue_rd,
        input  alu_stall, mem_ready, busy, wb_wren, wb_addr, wb_data
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data, issue_valid, issue_rd,
        output alu_stall, mem_ready, busy, wb_wren, wb_addr, wb_data
    );

endinterface

// File: rtl/wb_fifo.sv
// Memory-result queue: DEPTH entries (power of two), pointers wrap modulo depth.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  wb_req_t                  push_data,
    input  logic                     pop,
    output wb_req_t                  pop_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    wb_req_t         entries [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic            do_push;
    logic            do_pop;

    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;
    assign empty    = (count == '0);
    assign full     = (count == CW'(DEPTH));
    assign pop_data = entries[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) entries[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/writeback_arbiter.sv
// Arbitrates ALU and memory writebacks onto the register-file write port.
// Optional busy scoreboard enabled by defining WB_SCOREBOARD_EN.
module writeback_arbiter
    import wb_pkg::*;
#(
    parameter int unsigned LQ_DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    writeback_arbiter_if.slave   port
);

    localparam int unsigned CW = $clog2(LQ_DEPTH) + 1;

    wb_src_e         src;
    wb_req_t         sel_req;
    wb_req_t         q_head;
    wb_req_t         mem_req;
    logic            q_push;
    logic            q_pop;
    logic            q_empty;
    logic            q_full;
    logic [CW-1:0]   q_count;
    logic            mem_acc;

    assign mem_req.rd   = port.mem_rd;
    assign mem_req.data = port.mem_data;

    assign port.mem_ready = ~reset & ~q_full;
    assign port.alu_stall = (q_count == CW'(LQ_DEPTH));
    assign mem_acc        = port.mem_valid & port.mem_ready;

    always_comb begin
        src     = WB_NONE;
        sel_req = '0;
        if (port.alu_valid) begin
            src          = WB_ALU;
            sel_req.rd   = port.alu_rd;
            sel_req.data = port.alu_data;
        end else if (!q_empty) begin
            src     = WB_QUEUE;
            sel_req = q_head;
        end else if (mem_acc) begin
            src     = WB_BYPASS;
            sel_req = mem_req;
        end
    end

    assign q_pop  = (src == WB_QUEUE);
    assign q_push = mem_acc & (src != WB_BYPASS);

    wb_fifo #(.DEPTH(LQ_DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (q_push),
        .push_data (mem_req),
        .pop       (q_pop),
        .pop_data  (q_head),
        .count     (q_count),
        .empty     (q_empty),
        .full      (q_full)
    );

    // r0 writes still consume their slot but never reach the register file
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            port.wb_wren <= 1'b0;
            port.wb_addr <= '0;
            port.wb_data <= '0;
        end else begin
            port.wb_wren <= (src != WB_NONE) && (sel_req.rd != '0);
            if (src != WB_NONE) begin
                port.wb_addr <= sel_req.rd;
                port.wb_data <= sel_req.data;
            end
        end
    end

`ifdef WB_SCOREBOARD_EN
    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_nxt;

    // Set is applied after clear so a coincident issue keeps the bit high
    always_comb begin
        busy_nxt = busy_q;
        if ((src == WB_QUEUE || src == WB_BYPASS) && sel_req.rd != '0)
            busy_nxt[sel_req.rd] = 1'b0;
        if (port.issue_valid && port.issue_rd != '0)
            busy_nxt[port.issue_rd] = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) busy_q <= '0;
        else       busy_q <= busy_nxt;
    end

    assign port.busy = busy_q;
`else
    logic unused_issue;
    assign unused_issue = ^{port.issue_valid, port.issue_rd};
    assign port.busy    = '0;
`endif

    a_no_alu_during_stall: assert property (
        @(posedge clk) disable iff (reset) !(port.alu_valid && port.alu_stall)
    );

endmodule

// File: tb/tb_writeback_arbiter.sv
// Randomized and directed bench for writeback_arbiter against a queue-based reference model.
module tb_writeback_arbiter;
    import wb_pkg::*;

    localparam int unsigned LQ_DEPTH = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    writeback_arbiter_if bus();

    writeback_arbiter #(.LQ_DEPTH(LQ_DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .port  (bus.slave)
    );

    wb_req_t           mq[$];
    logic              exp_wren;
    logic [ADDR_W-1:0] exp_addr;
    logic [DATA_W-1:0] exp_data;
    logic [NREGS-1:0]  exp_busy;
    int                checks = 0;
    int                errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive_idle();
        bus.alu_valid   = 1'b0;
        bus.alu_rd      = '0;
        bus.alu_data    = '0;
        bus.mem_valid   = 1'b0;
        bus.mem_rd      = '0;
        bus.mem_data    = '0;
        bus.issue_valid = 1'b0;
        bus.issue_rd    = '0;
    endtask

    // One clock: check ready/stall, drive inputs, advance the model, then check outputs.
    task automatic cycle(input logic av, input logic [ADDR_W-1:0] ard, input logic [DATA_W-1:0] ad,
                         input logic mv, input logic [ADDR_W-1:0] mrd, input logic [DATA_W-1:0] md,
                         input logic iv, input logic [ADDR_W-1:0] ird);
        wb_req_t w;
        logic    have;
        logic    from_mem;
        logic    acc;
        check("mem_ready", bus.mem_ready, mq.size() < LQ_DEPTH);
        check("alu_stall", bus.alu_stall, mq.size() == LQ_DEPTH);
        if (mq.size() == LQ_DEPTH) av = 1'b0;
        bus.alu_valid   = av;
        bus.alu_rd      = ard;
        bus.alu_data    = ad;
        bus.mem_valid   = mv;
        bus.mem_rd      = mrd;
        bus.mem_data    = md;
        bus.issue_valid = iv;
        bus.issue_rd    = ird;

        acc      = mv && (mq.size() < LQ_DEPTH);
        have     = 1'b1;
        from_mem = 1'b0;
        w        = '0;
        if (av) begin
            w.rd = ard; w.data = ad;
        end else if (mq.size() != 0) begin
            w = mq.pop_front();
            from_mem = 1'b1;
        end else if (acc) begin
            w.rd = mrd; w.data = md;
            from_mem = 1'b1;
            acc = 1'b0;
        end else begin
            have = 1'b0;
        end
        if (acc) begin
            wb_req_t n;
            n.rd = mrd; n.data = md;
            mq.push_back(n);
        end
        exp_wren = have && (w.rd != 0);
        if (exp_wren) begin
            exp_addr = w.rd;
            exp_data = w.data;
        end
`ifdef WB_SCOREBOARD_EN
        if (from_mem && w.rd != 0) exp_busy[w.rd] = 1'b0;
        if (iv && ird != 0)        exp_busy[ird]  = 1'b1;
`endif

        @(posedge clk);
        #1;
        check("wb_wren", bus.wb_wren, exp_wren);
        if (exp_wren) begin
            check("wb_addr", bus.wb_addr, exp_addr);
            check("wb_data", bus.wb_data, exp_data);
        end
        check("busy", bus.busy, exp_busy);
    endtask

    task automatic idle();
        cycle(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive_idle();
        #1;
        check("rst_wren", bus.wb_wren, 1'b0);
        check("rst_addr", bus.wb_addr, 0);
        check("rst_data", bus.wb_data, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_stall", bus.alu_stall, 1'b0);
        check("rst_ready", bus.mem_ready, 1'b0);
        @(posedge clk);
        #1;
        check("rst_wren_hold", bus.wb_wren, 1'b0);
        check("rst_ready_hold", bus.mem_ready, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        mq.delete();
        exp_wren = 1'b0;
        exp_busy = '0;
        #1;
        check("ready_after_rst", bus.mem_ready, 1'b1);
        @(posedge clk);
        #1;
        check("no_wren_after_rst", bus.wb_wren, 1'b0);
    endtask

    initial begin
        exp_busy = '0;
        exp_wren = 1'b0;
        exp_addr = '0;
        exp_data = '0;
        do_reset();

        // memory bypass with empty queue
        cycle(1'b0, '0, '0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0);
        check("t1_wren", bus.wb_wren, 1'b1);
        check("t1_addr", bus.wb_addr, 5);
        check("t1_data", bus.wb_data, 32'hDEADBEEF);
        check("t1_empty", bus.alu_stall, 1'b0);
        idle();

        // ALU wins, memory queued then written next cycle
        cycle(1'b1, 5'd3, 32'h11, 1'b1, 5'd4, 32'h22, 1'b0, '0);
        check("t2_addr_a", bus.wb_addr, 3);
        check("t2_data_a", bus.wb_data, 32'h11);
        idle();
        check("t2_addr_m", bus.wb_addr, 4);
        check("t2_data_m", bus.wb_data, 32'h22);
        idle();

        // fill the queue behind continuous ALU traffic
        cycle(1'b1, 5'd1, 32'hA1, 1'b1, 5'd8, 32'hB1, 1'b0, '0);
        cycle(1'b1, 5'd2, 32'hA2, 1'b1, 5'd9, 32'hB2, 1'b0, '0);
        check("t3_stall", bus.alu_stall, 1'b1);
        check("t3_ready", bus.mem_ready, 1'b0);
        cycle(1'b0, '0, '0, 1'b1, 5'd10, 32'hB3, 1'b0, '0);
        check("t3_first", bus.wb_addr, 8);
        cycle(1'b0, '0, '0, 1'b1, 5'd10, 32'hB3, 1'b0, '0);
        check("t3_second", bus.wb_addr, 9);
        idle();
        check("t3_third", bus.wb_addr, 10);
        idle();

        // r0 never written
        cycle(1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, '0, '0, 1'b0, '0);
        check("t4_r0", bus.wb_wren, 1'b0);
        idle();

`ifdef WB_SCOREBOARD_EN
        cycle(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 5'd7);
        check("t5_set", bus.busy[7], 1'b1);
        cycle(1'b0, '0, '0, 1'b1, 5'd7, 32'h77, 1'b0, '0);
        check("t5_clr_wren", bus.wb_wren, 1'b1);
        check("t5_clr", bus.busy[7], 1'b0);
        cycle(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 5'd7);
        cycle(1'b0, '0, '0, 1'b1, 5'd7, 32'h78, 1'b1, 5'd7);
        check("t5_set_wins", bus.busy[7], 1'b1);
        cycle(1'b0, '0, '0, 1'b1, 5'd7, 32'h79, 1'b0, '0);
        idle();
`endif

        // reset with a full queue and pending busy bits
        cycle(1'b1, 5'd1, 32'hC1, 1'b1, 5'd12, 32'hD1, 1'b1, 5'd12);
        cycle(1'b1, 5'd2, 32'hC2, 1'b1, 5'd13, 32'hD2, 1'b1, 5'd13);
        do_reset();
        idle();

        for (int i = 0; i < 600; i++) begin
            cycle(1'($urandom_range(0, 1)), ADDR_W'($urandom_range(0, NREGS - 1)), $urandom,
                  1'($urandom_range(0, 1)), ADDR_W'($urandom_range(0, NREGS - 1)), $urandom,
                  1'($urandom_range(0, 3) == 0), ADDR_W'($urandom_range(0, NREGS - 1)));
        end
        repeat (4) idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
